// File: rtl/fp13_pkg.sv
// Shared types for the fp13 frame sorter: the 13-bit word layout
// {sign, exp[3:0], sig[7:0]} and the scheduler state encoding.
package fp13_pkg;

  localparam int FP13_W = 13;
  localparam int EXP_W  = 4;
  localparam int SIG_W  = 8;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [SIG_W-1:0] sig;
  } fp13_t;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    SORT  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Unsigned magnitude {exp, sig}; a word is zero when this is zero.
  function automatic logic [EXP_W+SIG_W-1:0] fp13_mag(input fp13_t w);
    return {w.exp, w.sig};
  endfunction

endpackage

// File: rtl/fp13_gt.sv
// Combinational strict greater-than on fp13 words. +0 and -0 are equal,
// and equal words give gt=0 so a bubble sort built on it stays stable.
module fp13_gt
  import fp13_pkg::*;
(
  input  fp13_t a,
  input  fp13_t b,
  output logic  gt
);

  logic [EXP_W+SIG_W-1:0] mag_a;
  logic [EXP_W+SIG_W-1:0] mag_b;
  logic                   both_zero;

  // Sign-magnitude ordering: negative magnitudes compare in reverse.
  always_comb begin
    mag_a     = fp13_mag(a);
    mag_b     = fp13_mag(b);
    both_zero = (mag_a == '0) && (mag_b == '0);
    gt        = 1'b0;
    if (a.sign == b.sign) begin
      if (a.sign == 1'b0) begin
        gt = (mag_a > mag_b);
      end else begin
        gt = (mag_a < mag_b);
      end
    end else begin
      gt = (a.sign == 1'b0) && !both_zero;
    end
  end

endmodule

// File: rtl/fp13_sort_scheduler.sv
// Frame sorter: loads up to DEPTH fp13 words, bubble-sorts them largest
// first using a single shared comparator (one compare per cycle), then
// drains the frame. Optional macro FP_SORT_EARLY_EXIT_EN ends the sort
// after the first pass that performs no swap.
module fp13_sort_scheduler
  import fp13_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [FP13_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [FP13_W-1:0] out_data,
  output logic              out_last,
  output logic              busy
);

  // The word count needs one extra bit so it can hold DEPTH itself.
  localparam logic [CW:0]   DEPTH_M1 = (CW+1)'(DEPTH - 1);
  localparam logic [CW:0]   N_ONE    = (CW+1)'(1);
  localparam logic [CW:0]   N_TWO    = (CW+1)'(2);
  localparam logic [CW-1:0] I_ONE    = CW'(1);

  state_t        state_reg, state_next;
  logic [CW:0]   n_reg, n_next;
  logic [CW-1:0] i_reg, i_next;
  logic [CW-1:0] pass_reg, pass_next;
  logic [CW-1:0] rd_reg, rd_next;

  logic          in_ready_reg;
  logic          out_valid_reg;
  logic          out_last_reg;
  logic          busy_reg;
  fp13_t         out_data_reg;

  fp13_t         mem [DEPTH];
  fp13_t         mem_next [DEPTH];

  logic [CW:0]   n_m1, n_m2, i_ext, pass_ext, rd_ext;
  logic [CW-1:0] i_p1;
  fp13_t         cmp_a, cmp_b;
  logic          gt_out;
  logic          accept, last_beat, swap, drain_hs;
  logic          pass_end, no_swap_pass, stop_sort;
`ifdef FP_SORT_EARLY_EXIT_EN
  logic          swapped_reg, swapped_next;
`endif

  assign n_m1     = n_reg - N_ONE;
  assign n_m2     = n_reg - N_TWO;
  assign i_ext    = {1'b0, i_reg};
  assign pass_ext = {1'b0, pass_reg};
  assign rd_ext   = {1'b0, rd_reg};
  assign i_p1     = i_reg + I_ONE;

  // The single comparator always looks at the adjacent pair (i+1, i).
  assign cmp_a = mem[i_p1];
  assign cmp_b = mem[i_reg];

  fp13_gt u_gt (
    .a  (cmp_a),
    .b  (cmp_b),
    .gt (gt_out)
  );

  assign accept    = (state_reg == LOAD) && in_valid && in_ready_reg;
  assign last_beat = in_last || (n_reg == DEPTH_M1);
  assign swap      = (state_reg == SORT) && gt_out;
  assign drain_hs  = out_valid_reg && out_ready;
  assign pass_end  = (i_ext == n_m2);

`ifdef FP_SORT_EARLY_EXIT_EN
  assign no_swap_pass = !(swapped_reg || swap);
`else
  assign no_swap_pass = 1'b0;
`endif
  assign stop_sort = (pass_ext == n_m2) || no_swap_pass;

  // Per-slot next value: load write, or one half of an adjacent swap.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_mem
    assign mem_next[gi] = (accept && (n_reg == (CW+1)'(gi))) ? fp13_t'(in_data) :
                          (swap && (i_reg == CW'(gi)))       ? mem[i_p1] :
                          (swap && (i_p1 == CW'(gi)))        ? mem[i_reg] :
                                                               mem[gi];
  end

  // Frame storage carries no reset; its contents are don't-care until loaded.
  always_ff @(posedge clk) begin
    mem <= mem_next;
  end

  // Next-state and counter sequencing for LOAD / SORT / DRAIN.
  always_comb begin
    state_next = state_reg;
    n_next     = n_reg;
    i_next     = i_reg;
    pass_next  = pass_reg;
    rd_next    = rd_reg;
`ifdef FP_SORT_EARLY_EXIT_EN
    swapped_next = swapped_reg;
`endif
    case (state_reg)
      LOAD: begin
        if (accept) begin
          n_next = n_reg + N_ONE;
          if (last_beat) begin
            i_next    = '0;
            pass_next = '0;
            rd_next   = '0;
`ifdef FP_SORT_EARLY_EXIT_EN
            swapped_next = 1'b0;
`endif
            state_next = (n_reg == '0) ? DRAIN : SORT;
          end
        end
      end
      SORT: begin
        if (pass_end) begin
          if (stop_sort) begin
            state_next = DRAIN;
            rd_next    = '0;
          end else begin
            i_next    = '0;
            pass_next = pass_reg + I_ONE;
`ifdef FP_SORT_EARLY_EXIT_EN
            swapped_next = 1'b0;
`endif
          end
        end else begin
          i_next = i_p1;
`ifdef FP_SORT_EARLY_EXIT_EN
          swapped_next = swapped_reg || swap;
`endif
        end
      end
      DRAIN: begin
        if (drain_hs) begin
          if (rd_ext == n_m1) begin
            state_next = LOAD;
            n_next     = '0;
            rd_next    = '0;
          end else begin
            rd_next = rd_reg + I_ONE;
          end
        end
      end
      default: state_next = LOAD;
    endcase
  end

  // State, counters and registered outputs derived from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= LOAD;
      n_reg         <= '0;
      i_reg         <= '0;
      pass_reg      <= '0;
      rd_reg        <= '0;
`ifdef FP_SORT_EARLY_EXIT_EN
      swapped_reg   <= 1'b0;
`endif
      in_ready_reg  <= 1'b0;
      out_valid_reg <= 1'b0;
      out_last_reg  <= 1'b0;
      busy_reg      <= 1'b0;
      out_data_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      n_reg         <= n_next;
      i_reg         <= i_next;
      pass_reg      <= pass_next;
      rd_reg        <= rd_next;
`ifdef FP_SORT_EARLY_EXIT_EN
      swapped_reg   <= swapped_next;
`endif
      in_ready_reg  <= (state_next == LOAD);
      busy_reg      <= (state_next == SORT);
      out_valid_reg <= (state_next == DRAIN);
      out_last_reg  <= (state_next == DRAIN) && ({1'b0, rd_next} == (n_next - N_ONE));
      out_data_reg  <= (state_next == DRAIN) ? mem_next[rd_next] : '0;
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign out_last  = out_last_reg;
  assign busy      = busy_reg;
  assign out_data  = out_data_reg;

endmodule

// File: tb/tb_fp13_sort_scheduler.sv
// Directed bench for fp13_sort_scheduler: reset mid-sort, reversed and
// already-sorted 8-word frames, mixed signs, +0/-0, backpressure and a
// single-word frame. Honours FP_SORT_EARLY_EXIT_EN for sort-length checks.
module tb_fp13_sort_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [12:0] in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [12:0] out_data;
  logic        out_last;
  logic        busy;

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total    = 0;
  int cyc;

  logic [12:0] in_w  [8];
  logic [12:0] exp_w [8];

  fp13_sort_scheduler #(.DEPTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [12:0] mk(input logic s, input logic [3:0] e, input logic [7:0] m);
    return {s, e, m};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
    end
  endtask

  // Called at a negedge; returns at the negedge after the word is accepted.
  task automatic send_word(input logic [12:0] w, input logic last);
    int guard = 0;
    in_valid = 1'b1;
    in_data  = w;
    in_last  = last;
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    chk("in_ready_wait", guard < 200, 1);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_frame(input int n, input bit with_last);
    for (int k = 0; k < n; k++) begin
      send_word(in_w[k], with_last && (k == n - 1));
    end
  endtask

  // Counts busy cycles until the first out_valid.
  task automatic measure_sort(output int c);
    int guard = 0;
    c = 0;
    while (!out_valid && guard < 200) begin
      if (busy) c++;
      @(negedge clk);
      guard++;
    end
    chk("sort_timeout", out_valid, 1);
    chk("busy_in_drain", busy, 0);
  endtask

  task automatic drain(input string name, input int n, input bit toggle);
    int k = 0;
    int guard = 0;
    bit phase = 1'b0;
    while (k < n && guard < 400) begin
      out_ready = toggle ? phase : 1'b1;
      chk({name, "_out_valid"}, out_valid, 1);
      chk({name, "_out_data"}, out_data, exp_w[k]);
      chk({name, "_out_last"}, out_last, (k == n - 1));
      chk({name, "_in_ready_low"}, in_ready, 0);
      if (out_ready) begin
        $display("%s drain word %0d data=0x%03h last=%0b", name, k, out_data, out_last);
        k++;
      end
      phase = ~phase;
      @(negedge clk);
      guard++;
    end
    out_ready = 1'b0;
    chk({name, "_drain_count"}, k, n);
    chk({name, "_back_to_load"}, in_ready, 1);
    chk({name, "_valid_drop"}, out_valid, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_last", out_last, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1);

    // Reversed ascending frame, interrupted by reset mid-sort.
    for (int k = 0; k < 8; k++) in_w[k] = mk(1'b0, 4'(k), 8'h80);
    send_frame(8, 1'b0);
    repeat (5) @(negedge clk);
    chk("midsort_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_busy", busy, 0);
    chk("async_rst_in_ready", in_ready, 0);
    chk("async_rst_out_valid", out_valid, 0);
    chk("async_rst_out_data", out_data, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rerelease_in_ready", in_ready, 1);
    chk("rerelease_busy", busy, 0);

    // Same frame after reset: full 49-cycle sort in both builds.
    send_frame(8, 1'b0);
    measure_sort(cyc);
    chk("rev_busy_cycles", cyc, 49);
    for (int k = 0; k < 8; k++) exp_w[k] = mk(1'b0, 4'(7 - k), 8'h80);
    drain("rev", 8, 1'b0);

    // Already sorted frame, drained with out_ready toggling.
    for (int k = 0; k < 8; k++) in_w[k] = mk(1'b0, 4'(7 - k), 8'h80);
    send_frame(8, 1'b0);
    measure_sort(cyc);
`ifdef FP_SORT_EARLY_EXIT_EN
    chk("sorted_busy_cycles", cyc, 7);
`else
    chk("sorted_busy_cycles", cyc, 49);
`endif
    drain("sorted_bp", 8, 1'b1);

    // Mixed signs, frame closed by in_last on the 4th word.
    in_w[0] = mk(1'b1, 4'd3, 8'h01);
    in_w[1] = mk(1'b0, 4'd0, 8'h01);
    in_w[2] = mk(1'b1, 4'd0, 8'h01);
    in_w[3] = mk(1'b0, 4'd0, 8'h00);
    send_frame(4, 1'b1);
    measure_sort(cyc);
    chk("mixed_busy_cycles", cyc, 9);
    exp_w[0] = mk(1'b0, 4'd0, 8'h01);
    exp_w[1] = mk(1'b0, 4'd0, 8'h00);
    exp_w[2] = mk(1'b1, 4'd0, 8'h01);
    exp_w[3] = mk(1'b1, 4'd3, 8'h01);
    drain("mixed", 4, 1'b0);

    // -0 then +0 must not swap.
    in_w[0] = mk(1'b1, 4'd0, 8'h00);
    in_w[1] = mk(1'b0, 4'd0, 8'h00);
    send_frame(2, 1'b1);
    measure_sort(cyc);
    chk("zero_busy_cycles", cyc, 1);
    exp_w[0] = in_w[0];
    exp_w[1] = in_w[1];
    drain("zeros", 2, 1'b0);

    // Single-word frame skips SORT entirely.
    in_w[0] = mk(1'b0, 4'd5, 8'h3C);
    send_frame(1, 1'b1);
    chk("single_valid_next", out_valid, 1);
    measure_sort(cyc);
    chk("single_busy_cycles", cyc, 0);
    exp_w[0] = in_w[0];
    drain("single", 1, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
